// File: rtl/sw_cond_pkg.sv
// Shared types and defaults for the sw_cond push-button conditioner.
package sw_cond_pkg;

  localparam int unsigned TC_W = 16;

  localparam int unsigned DEF_NUM_SW     = 4;
  localparam int unsigned DEF_TICK_DIV   = 500000;
  localparam int unsigned DEF_DEB_TICKS  = 2;
  localparam int unsigned DEF_LONG_TICKS = 100;
  localparam int unsigned DEF_REP_TICKS  = 20;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_HELD        = 3'd2,
    ST_REPEAT      = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } sw_state_e;

  typedef logic [TC_W-1:0] tc_t;

  // Tick counter increment that sticks at all-ones.
  function automatic tc_t tc_sat_inc(input tc_t v);
    return (v == '1) ? v : v + TC_W'(1);
  endfunction

endpackage

// File: rtl/sw_cond_ch.sv
// One key: 2-flop synchronizer, debounce/long/repeat FSM and registered pulses.
// Auto-repeat is built only when SW_COND_REPEAT_EN is defined.
module sw_cond_ch
  import sw_cond_pkg::*;
#(
  parameter int unsigned DEB_TICKS  = DEF_DEB_TICKS,
  parameter int unsigned LONG_TICKS = DEF_LONG_TICKS,
  parameter int unsigned REP_TICKS  = DEF_REP_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
  input  logic i_tick,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam tc_t DEB_TC  = TC_W'(DEB_TICKS);
  localparam tc_t LONG_TC = TC_W'(LONG_TICKS);
`ifdef SW_COND_REPEAT_EN
  localparam tc_t REP_TC  = TC_W'(REP_TICKS);
`endif

  if (DEB_TICKS == 0 || LONG_TICKS == 0 || REP_TICKS == 0) begin : g_bad_param
    $error("sw_cond_ch: tick parameters must be nonzero");
  end

  logic      sync1;
  logic      sync2;
  logic      sp;
  sw_state_e state;
  tc_t       tc;
  tc_t       tc_inc;
  logic      long_done;

  assign sp     = ~sync2;
  assign tc_inc = tc_sat_inc(tc);

  // A level change of sp always wins over a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      state     <= ST_IDLE;
      tc        <= '0;
      long_done <= 1'b0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
`ifdef SW_COND_REPEAT_EN
      o_repeat  <= 1'b0;
`endif
    end else begin
      sync1     <= i_sw;
      sync2     <= sync1;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
`ifdef SW_COND_REPEAT_EN
      o_repeat  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (sp) begin
            state <= ST_DEB_PRESS;
            tc    <= '0;
          end
        end
        ST_DEB_PRESS: begin
          if (!sp) begin
            state <= ST_IDLE;
            tc    <= '0;
          end else if (i_tick) begin
            if (tc_inc == DEB_TC) begin
              state     <= ST_HELD;
              tc        <= '0;
              long_done <= 1'b0;
              o_press   <= 1'b1;
              o_level   <= 1'b1;
            end else begin
              tc <= tc_inc;
            end
          end
        end
        ST_HELD: begin
          if (!sp) begin
            state <= ST_DEB_RELEASE;
            tc    <= '0;
          end else if (i_tick) begin
            if (tc_inc == LONG_TC && !long_done) begin
              o_long    <= 1'b1;
              long_done <= 1'b1;
`ifdef SW_COND_REPEAT_EN
              state     <= ST_REPEAT;
              tc        <= '0;
`else
              tc        <= tc_inc;
`endif
            end else begin
              tc <= tc_inc;
            end
          end
        end
`ifdef SW_COND_REPEAT_EN
        ST_REPEAT: begin
          if (!sp) begin
            state <= ST_DEB_RELEASE;
            tc    <= '0;
          end else if (i_tick) begin
            if (tc_inc == REP_TC) begin
              o_repeat <= 1'b1;
              tc       <= '0;
            end else begin
              tc <= tc_inc;
            end
          end
        end
`endif
        // A bounce back to pressed returns to HELD with long_done kept.
        ST_DEB_RELEASE: begin
          if (sp) begin
            state <= ST_HELD;
            tc    <= '0;
          end else if (i_tick) begin
            if (tc_inc == DEB_TC) begin
              state     <= ST_IDLE;
              tc        <= '0;
              o_release <= 1'b1;
              o_level   <= 1'b0;
            end else begin
              tc <= tc_inc;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          tc      <= '0;
          o_level <= 1'b0;
        end
      endcase
    end
  end

`ifndef SW_COND_REPEAT_EN
  assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/sw_cond.sv
// Push-button conditioner top: shared debounce-tick prescaler plus one channel per key.
// Optional auto-repeat is enabled by defining SW_COND_REPEAT_EN.
module sw_cond
  import sw_cond_pkg::*;
#(
  parameter int unsigned NUM_SW     = DEF_NUM_SW,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned DEB_TICKS  = DEF_DEB_TICKS,
  parameter int unsigned LONG_TICKS = DEF_LONG_TICKS,
  parameter int unsigned REP_TICKS  = DEF_REP_TICKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] i_sw,
  output logic [NUM_SW-1:0] o_level,
  output logic [NUM_SW-1:0] o_press,
  output logic [NUM_SW-1:0] o_release,
  output logic [NUM_SW-1:0] o_long,
  output logic [NUM_SW-1:0] o_repeat,
  output logic              o_tick
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  if (TICK_DIV == 0 || NUM_SW == 0) begin : g_bad_param
    $error("sw_cond: TICK_DIV and NUM_SW must be nonzero");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;

  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
  end

  // o_tick is the registered terminal count, so the first tick lands TICK_DIV cycles after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      o_tick  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      o_tick  <= (div_cnt == DIV_LAST);
    end
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    sw_cond_ch #(
      .DEB_TICKS (DEB_TICKS),
      .LONG_TICKS(LONG_TICKS),
      .REP_TICKS (REP_TICKS)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_sw     (i_sw[i]),
      .i_tick   (o_tick),
      .o_level  (o_level[i]),
      .o_press  (o_press[i]),
      .o_release(o_release[i]),
      .o_long   (o_long[i]),
      .o_repeat (o_repeat[i])
    );
  end

endmodule

// File: tb/tb_sw_cond.sv
// Bench for sw_cond: per-key behavioural model (level + debounce/hold counters) compared
// every cycle, plus literal timing/count expectations for the directed scenarios.
module tb_sw_cond;

  localparam int unsigned N  = 4;
  localparam int unsigned TD = 4;
  localparam int unsigned DT = 2;
  localparam int unsigned LT = 6;
  localparam int unsigned RT = 3;
`ifdef SW_COND_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] i_sw;
  logic [N-1:0] o_level, o_press, o_release, o_long, o_repeat;
  logic         o_tick;

  sw_cond #(
    .NUM_SW(N), .TICK_DIV(TD), .DEB_TICKS(DT), .LONG_TICKS(LT), .REP_TICKS(RT)
  ) dut (
    .clk(clk), .rst(rst), .i_sw(i_sw),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_repeat(o_repeat), .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [N-1:0] e_level, e_press, e_release, e_long, e_repeat;
  logic         e_tick;
  logic [N-1:0] m_s1, m_s2;
  int           m_cyc;
  bit           m_valid = 1'b0;
  bit           lvl[N], dis_prev[N], ldone[N], rmode[N];
  int           deb[N], hold[N], rep[N];
  bit           m_tk;

  // Debounced level plus counts: ticks of disagreement, ticks held, ticks since last repeat.
  task automatic key_step(input int k, input bit sp, input bit tk);
    bit dis;
    e_press[k] = 1'b0; e_release[k] = 1'b0; e_long[k] = 1'b0; e_repeat[k] = 1'b0;
    dis = (sp != lvl[k]);
    if (dis) begin
      if (!dis_prev[k]) begin
        deb[k] = 0;
        dis_prev[k] = 1'b1;
      end else if (tk) begin
        deb[k]++;
        if (deb[k] == int'(DT)) begin
          lvl[k] = sp;
          dis_prev[k] = 1'b0;
          if (sp) begin
            e_press[k] = 1'b1; ldone[k] = 1'b0; hold[k] = 0; rmode[k] = 1'b0;
          end else begin
            e_release[k] = 1'b1;
          end
        end
      end
    end else if (dis_prev[k]) begin
      dis_prev[k] = 1'b0; hold[k] = 0; rmode[k] = 1'b0;
    end else if (lvl[k] && tk) begin
      if (rmode[k]) begin
        rep[k]++;
        if (rep[k] == int'(RT)) begin e_repeat[k] = 1'b1; rep[k] = 0; end
      end else begin
        if (hold[k] < 65535) hold[k]++;
        if (hold[k] >= int'(LT) && !ldone[k]) begin
          e_long[k] = 1'b1; ldone[k] = 1'b1;
          if (REP_ON) begin rmode[k] = 1'b1; rep[k] = 0; end
        end
      end
    end
    e_level[k] = lvl[k];
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_cyc = 0; e_tick = 1'b0;
      m_s1 = '1; m_s2 = '1;
      e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
      for (int k = 0; k < N; k++) begin
        lvl[k] = 0; dis_prev[k] = 0; ldone[k] = 0; rmode[k] = 0;
        deb[k] = 0; hold[k] = 0; rep[k] = 0;
      end
    end else begin
      m_tk = e_tick;
      for (int k = 0; k < N; k++) key_step(k, ~m_s2[k], m_tk);
      m_s2 = m_s1;
      m_s1 = i_sw;
      m_cyc++;
      e_tick = (m_cyc % TD) == 0;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_tick, first_tick;
  int n_press[N], n_rel[N], n_long[N], n_rep[N];
  int press_at[N], long_at[N], rep_first[N], rep_last[N];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_tick = 0; first_tick = 0;
    for (int k = 0; k < N; k++) begin
      n_press[k] = 0; n_rel[k] = 0; n_long[k] = 0; n_rep[k] = 0;
      press_at[k] = 0; long_at[k] = 0; rep_first[k] = 0; rep_last[k] = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (m_valid) begin
      chk("level", 64'(o_level), 64'(e_level));
      chk("press", 64'(o_press), 64'(e_press));
      chk("release", 64'(o_release), 64'(e_release));
      chk("long", 64'(o_long), 64'(e_long));
      chk("repeat", 64'(o_repeat), 64'(e_repeat));
      chk("tick", 64'(o_tick), 64'(e_tick));
    end
    for (int k = 0; k < N; k++) begin
      if (o_press[k] === 1'b1) begin n_press[k]++; press_at[k] = cyc; end
      if (o_release[k] === 1'b1) n_rel[k]++;
      if (o_long[k] === 1'b1) begin n_long[k]++; long_at[k] = cyc; end
      if (o_repeat[k] === 1'b1) begin
        if (n_rep[k] == 0) rep_first[k] = cyc;
        rep_last[k] = cyc;
        n_rep[k]++;
      end
    end
    if (o_tick === 1'b1) begin
      n_tick++;
      if (first_tick == 0) first_tick = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  int rep_snap;

  initial begin
    rst = 1'b1;
    i_sw = '1;
    clear_counts();
    run(3);

    // Idle after reset: tick cadence, no key activity.
    rst = 1'b0; cyc = 0; clear_counts();
    run(200);
    chk("first_tick", 64'(first_tick), 64'd4);
    chk("tick_count", 64'(n_tick), 64'd50);
    chk("idle_press", 64'(n_press[0] + n_press[1] + n_press[2] + n_press[3]), 64'd0);

    // Key 0: two-cycle glitch is rejected.
    clear_counts();
    i_sw[0] = 1'b0; run(2);
    i_sw[0] = 1'b1; run(40);
    chk("glitch_press", 64'(n_press[0]), 64'd0);
    chk("glitch_release", 64'(n_rel[0]), 64'd0);

    // Key 1: 25-tick hold, long press and auto-repeat.
    clear_counts();
    i_sw[1] = 1'b0; run(100);
    i_sw[1] = 1'b1; run(40);
    chk("k1_press", 64'(n_press[1]), 64'd1);
    chk("k1_long", 64'(n_long[1]), 64'd1);
    chk("k1_long_delay", 64'(long_at[1] - press_at[1]), 64'd24);
    chk("k1_repeats", 64'(n_rep[1]), REP_ON ? 64'd5 : 64'd0);
    if (n_rep[1] > 0) begin
      chk("k1_first_rep", 64'(rep_first[1] - long_at[1]), 64'd12);
      chk("k1_rep_span", 64'(rep_last[1] - rep_first[1]), 64'd48);
    end
    chk("k1_release", 64'(n_rel[1]), 64'd1);

    // Key 2: long press, one-tick release bounce, continued hold.
    clear_counts();
    i_sw[2] = 1'b0; run(50);
    i_sw[2] = 1'b1; run(4);
    i_sw[2] = 1'b0;
    rep_snap = n_rep[2];
    run(60);
    chk("k2_press", 64'(n_press[2]), 64'd1);
    chk("k2_long", 64'(n_long[2]), 64'd1);
    chk("k2_no_release", 64'(n_rel[2]), 64'd0);
    chk("k2_no_rep_after_bounce", 64'(n_rep[2] - rep_snap), 64'd0);
    i_sw[2] = 1'b1; run(40);
    chk("k2_release", 64'(n_rel[2]), 64'd1);
    clear_counts();
    i_sw[2] = 1'b0; run(60);
    chk("k2_relong", 64'(n_long[2]), 64'd1);
    chk("k2_rep_resumes", 64'(n_rep[2] > 0), 64'(REP_ON));
    i_sw[2] = 1'b1; run(40);

    // Keys 0 and 3 together.
    clear_counts();
    i_sw[0] = 1'b0; i_sw[3] = 1'b0; run(20);
    chk("k0_press", 64'(n_press[0]), 64'd1);
    chk("k3_press", 64'(n_press[3]), 64'd1);
    chk("k03_same_cycle", 64'(press_at[0] - press_at[3]), 64'd0);
    chk("k12_quiet", 64'(n_press[1] + n_press[2]), 64'd0);
    i_sw[0] = 1'b1; i_sw[3] = 1'b1; run(30);

    // Key 1 held through a reset.
    clear_counts();
    i_sw[1] = 1'b0; run(50);
    rst = 1'b1; step();
    chk("reset_outputs", 64'({o_level, o_press, o_release, o_long, o_repeat, o_tick}), 64'd0);
    rst = 1'b0; cyc = 0; clear_counts();
    run(20);
    chk("k1_repress", 64'(n_press[1]), 64'd1);
    chk("k1_repress_at", 64'(press_at[1]), 64'd9);
    chk("k1_no_rel_on_reset", 64'(n_rel[1]), 64'd0);
    i_sw[1] = 1'b1; run(40);

    // Random toggling on all keys.
    for (int it = 0; it < 60; it++) begin
      int k;
      k = int'($urandom_range(N - 1, 0));
      i_sw[k] = ~i_sw[k];
      run(int'($urandom_range(60, 1)));
    end
    i_sw = '1;
    run(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
